// File: rtl/cbc_stream.sv
// cbc_stream: streaming XOR cipher with optional CBC chaining.
// One SYNC_SIZE-bit word is handled per cycle. The key is repeated across
// the word, a loadable IV seeds the chain, and the result sits in a single
// output register behind a valid/ready handshake.
module cbc_stream #(
    parameter int BLOCK_SIZE = 8,
    parameter int SYNC_SIZE  = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLOCK_SIZE-1:0] key,
    input  logic [SYNC_SIZE-1:0]  iv,
    input  logic                  iv_load,
    input  logic                  mode_cbc,
    input  logic                  decrypt,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYNC_SIZE-1:0]  data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYNC_SIZE-1:0]  data_out,
    output logic [CNT_W-1:0]      blk_count,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [BLOCK_SIZE-1:0] key_reg;
    logic [SYNC_SIZE-1:0]  chain_reg;
    logic                  mode_reg;
    logic                  dir_reg;
    logic [SYNC_SIZE-1:0]  key_rep;
    logic [SYNC_SIZE-1:0]  chain_mix;
    logic [SYNC_SIZE-1:0]  x_word;
    logic                  in_xfer;
    logic                  out_xfer;

    // Repeat the latched key across the whole word; SYNC_SIZE need not be a multiple of BLOCK_SIZE.
    always_comb begin
        key_rep = '0;
        for (int i = 0; i < SYNC_SIZE; i++) begin
            key_rep[i] = key_reg[i % BLOCK_SIZE];
        end
    end

    // Cipher word: data ^ key, plus the chain value only in CBC mode.
    always_comb begin
        chain_mix = mode_reg ? chain_reg : '0;
        x_word    = data_in ^ key_rep ^ chain_mix;
    end

    // State register; only reset brings the block back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready depends combinationally on out_ready for full throughput.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (iv_load) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = enable & ~iv_load & (~out_valid | out_ready);
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Datapath: iv_load re-primes everything and drops a pending word; otherwise accept/drain words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg   <= '0;
            chain_reg <= '0;
            mode_reg  <= 1'b0;
            dir_reg   <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            blk_count <= '0;
        end else if (iv_load) begin
            key_reg   <= key;
            chain_reg <= iv;
            mode_reg  <= mode_cbc;
            dir_reg   <= decrypt;
            out_valid <= 1'b0;
            blk_count <= '0;
        end else if (in_xfer) begin
            data_out  <= x_word;
            out_valid <= 1'b1;
            blk_count <= blk_count + CNT_W'(1);
            if (mode_reg) begin
                chain_reg <= dir_reg ? data_in : x_word;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/cbc_stream.md
Name: cbc_stream

Overview:
- Clocked, streaming successor to the bitwise XOR ECB cipher. Each cycle it handles one SYNC_SIZE-bit word.
- Key is repeated across the word: key_rep[i] = key[i % BLOCK_SIZE].
- Adds CBC chaining with a loadable IV, encrypt/decrypt direction, ECB/CBC mode select, valid/ready handshakes, a registered output and a word counter.
- Sits between the plaintext source and the transmit/storage path.

Parameters:
- BLOCK_SIZE, 8, key width in bits; must be >= 1.
- SYNC_SIZE, 32, data word width in bits; must be >= 1; need not be a multiple of BLOCK_SIZE.
- CNT_W, 16, width of the processed-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key  input  BLOCK_SIZE  cipher key; captured on iv_load.
- iv  input  SYNC_SIZE  initialisation vector; captured on iv_load.
- iv_load  input  1  single-cycle pulse: capture key and iv, clear counter, enter RUN.
- mode_cbc  input  1  0 = ECB, 1 = CBC; captured on iv_load.
- decrypt  input  1  0 = encrypt, 1 = decrypt; captured on iv_load.
- enable  input  1  when 0, no new input is accepted; output drain is unaffected.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept data_in this cycle.
- data_in  input  SYNC_SIZE  plaintext when encrypting, ciphertext when decrypting.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  SYNC_SIZE  ciphertext when encrypting, plaintext when decrypting.
- blk_count  output  CNT_W  number of words accepted since the last iv_load.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; out_valid = 0; data_out = 0; blk_count = 0; busy = 0.
  - Internal key_reg, chain_reg, mode and direction registers = 0.
- State machine, two states:
  - IDLE: in_ready = 0. iv_load moves to RUN.
  - RUN: stays in RUN. A further iv_load re-primes in place. Only rst returns to IDLE.
- iv_load (any state), on the next edge:
  - key_reg <= key; chain_reg <= iv; latch mode_cbc and decrypt.
  - blk_count <= 0; out_valid <= 0, dropping any pending word.
  - in_ready is forced to 0 during the iv_load cycle, so no input transfer coincides with it.
- Ready rule in RUN: in_ready = enable & ~iv_load & (~out_valid | out_ready).
  - This is combinational from out_ready, giving full throughput with a single output register.
- Input transfer occurs when in_valid & in_ready. On that edge:
  - x = data_in ^ key_rep ^ (mode_cbc ? chain_reg : 0).
  - data_out <= x; out_valid <= 1; blk_count <= blk_count + 1, wrapping from all-ones to 0.
  - CBC encrypt: chain_reg <= x (ciphertext).
  - CBC decrypt: chain_reg <= data_in (ciphertext).
  - ECB: chain_reg unchanged.
- Output transfer occurs when out_valid & out_ready; out_valid clears unless a new input transfer happens in the same cycle.
- Latency and throughput: 1 cycle from input transfer to out_valid; 1 word per cycle sustained.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. data_out and out_valid hold stable until accepted.
- Simultaneous output and input transfer: data_out is replaced with the new word and out_valid stays 1.
- enable=0 mid-stream: the pending output still drains. chain_reg and blk_count hold.
- rst asserted mid-operation: immediate return to reset values. The in-flight word is lost and chain state is lost.
- key, iv, mode_cbc and decrypt changes outside iv_load have no effect.

Test Plan:
- Reset values: assert rst with out_valid=1 -> out_valid, data_out, blk_count and busy all 0 immediately; in_ready=0 in IDLE even with in_valid=1.
- CBC encrypt (BLOCK_SIZE=8, SYNC_SIZE=16, key=8'hA5, iv=16'h1234, out_ready=1):
  - Inputs 16'h0000 then 16'hFFFF -> data_out 16'hB791 then 16'hEDCB, each 1 cycle after accept.
  - blk_count ends at 2.
- CBC decrypt, same key and iv: inputs 16'hB791, 16'hEDCB -> data_out 16'h0000, 16'hFFFF.
- ECB, key=8'hA5: input 16'h0000 twice -> 16'hA5A5 both times; chain_reg is ignored.
- Backpressure: hold out_ready=0 for 3 cycles after the first output -> in_ready=0, data_out stable at 16'hB791; release -> second word accepted in the same cycle, stream continues correctly.
- iv_load mid-stream with out_valid=1 and in_valid=1 -> no input accepted that cycle; next cycle out_valid=0, blk_count=0, chain restarts from the new iv.
- Counter wrap (CNT_W=2): 5 words -> blk_count 1, 2, 3, 0, 1.
